// File: rtl/fifo_pkg.sv
// Shared types and pointer-code helpers for the dual-clock FIFO controllers.
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 6;

    typedef logic [FIFO_ADDR_WIDTH:0] ptr_t;

    // Width-agnostic: pass narrower pointers zero-extended and truncate the result.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        logic        acc;
        acc = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            acc    = acc ^ gray[i];
            bin[i] = acc;
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_gray2bin_conv.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all Gray bits at or above it.
module gray2bin_conv #(
    parameter int W = 7
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            assign bin[gi] = ^gray[W-1:gi];
        end
    endgenerate

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the dual-clock FIFO: write pointer, memory strobe/address,
// full / almost_full / level flags and a sticky overflow flag, all in the write clock domain.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int AF_THRESH  = 56
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rq2_rptr,
    input  logic                  clr_ovf,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  overflow
);

    typedef logic [ADDR_WIDTH:0] wptr_t;

    localparam wptr_t AF_LEVEL = wptr_t'(AF_THRESH);

    wptr_t wbin_reg;
    wptr_t wbin_next;
    wptr_t wgray_next;
    wptr_t rbin;
    wptr_t level_next;
    wptr_t full_cmp;
    logic  push;

    gray2bin_conv #(.W(ADDR_WIDTH + 1)) u_rptr_conv (
        .gray (rq2_rptr),
        .bin  (rbin)
    );

    // Gating with rst_n keeps the memory strobe quiet while the block is held in reset.
    always_comb begin
        push       = wr_en & ~full & rst_n;
        wbin_next  = wbin_reg + wptr_t'(push);
        wgray_next = wptr_t'(bin2gray(32'(wbin_next)));
        level_next = wbin_next - rbin;
        full_cmp   = {~rq2_rptr[ADDR_WIDTH -: 2], rq2_rptr[ADDR_WIDTH-2:0]};
    end

    assign mem_we = push;
    assign waddr  = wbin_reg[ADDR_WIDTH-1:0];

    // Flags look at next-state pointers so full asserts without a bubble after the last slot fills.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_reg    <= '0;
            wptr        <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wlevel      <= '0;
            overflow    <= 1'b0;
        end else begin
            wbin_reg    <= wbin_next;
            wptr        <= wgray_next;
            full        <= (wgray_next == full_cmp);
            almost_full <= (level_next >= AF_LEVEL);
            wlevel      <= level_next;
            if (wr_en && full)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl: a table of single-cycle vectors plus hand-written multi-cycle sequences.
module tb_fifo_wr_ctrl;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [6:0] rq2_rptr;
    logic       clr_ovf;
    logic       mem_we;
    logic [5:0] waddr;
    logic [6:0] wptr;
    logic       full;
    logic       almost_full;
    logic [6:0] wlevel;
    logic       overflow;

    int total;
    int bad;

    fifo_wr_ctrl #(.ADDR_WIDTH(6), .AF_THRESH(56)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .rq2_rptr    (rq2_rptr),
        .clr_ovf     (clr_ovf),
        .mem_we      (mem_we),
        .waddr       (waddr),
        .wptr        (wptr),
        .full        (full),
        .almost_full (almost_full),
        .wlevel      (wlevel),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [6:0] rptr;
        logic       clr;
        logic       exp_we;
        logic [5:0] exp_waddr;
        logic [6:0] exp_wptr;
        logic       exp_full;
        logic       exp_af;
        logic [6:0] exp_lvl;
        logic       exp_ovf;
    } vec_t;

    vec_t tbl[6];

    function automatic logic [6:0] g7(input int v);
        logic [6:0] b;
        b = 7'(v);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [23:0] snap();
        return {mem_we, waddr, wptr, full, almost_full, wlevel, overflow};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        clr_ovf  = 1'b0;
        rq2_rptr = '0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Order: wr, rptr, clr | we, waddr | wptr, full, af, lvl, ovf
        tbl[0] = '{1'b1, 7'd0, 1'b0, 1'b1, 6'd0, 7'd1, 1'b0, 1'b0, 7'd1, 1'b0};
        tbl[1] = '{1'b0, 7'd0, 1'b0, 1'b0, 6'd1, 7'd1, 1'b0, 1'b0, 7'd1, 1'b0};
        tbl[2] = '{1'b1, 7'd0, 1'b0, 1'b1, 6'd1, 7'd3, 1'b0, 1'b0, 7'd2, 1'b0};
        tbl[3] = '{1'b1, 7'd1, 1'b0, 1'b1, 6'd2, 7'd2, 1'b0, 1'b0, 7'd2, 1'b0};
        tbl[4] = '{1'b0, 7'd2, 1'b1, 1'b0, 6'd3, 7'd2, 1'b0, 1'b0, 7'd0, 1'b0};
        tbl[5] = '{1'b1, 7'd2, 1'b0, 1'b1, 6'd3, 7'd6, 1'b0, 1'b0, 7'd1, 1'b0};

        rst_n    = 1'b0;
        wr_en    = 1'b0;
        rq2_rptr = '0;
        clr_ovf  = 1'b0;
        #2;
        check("reset_held", 32'(snap()), 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            cyc();
            check($sformatf("idle[%0d]", i), 32'(snap()), 32'd0);
        end

        for (int i = 0; i < 6; i++) begin
            wr_en    = tbl[i].wr;
            rq2_rptr = tbl[i].rptr;
            clr_ovf  = tbl[i].clr;
            #1;
            check($sformatf("vec%0d_comb", i), 32'({mem_we, waddr}),
                  32'({tbl[i].exp_we, tbl[i].exp_waddr}));
            cyc();
            check($sformatf("vec%0d_reg", i), 32'({wptr, full, almost_full, wlevel, overflow}),
                  32'({tbl[i].exp_wptr, tbl[i].exp_full, tbl[i].exp_af, tbl[i].exp_lvl, tbl[i].exp_ovf}));
            $display("vec %0d: wr=%0b rptr=%0h clr=%0b -> we=%0b waddr=%0d wptr=%0h lvl=%0d",
                     i, tbl[i].wr, tbl[i].rptr, tbl[i].clr, mem_we, waddr, wptr, wlevel);
        end
        wr_en   = 1'b0;
        clr_ovf = 1'b0;

        // Fill from empty with the read pointer parked at 0.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            wr_en = 1'b1;
            #1;
            check($sformatf("fill_comb[%0d]", i), 32'({mem_we, waddr}), 32'({1'b1, 6'(i)}));
            cyc();
            check($sformatf("fill_reg[%0d]", i), 32'({wptr, full, almost_full, wlevel}),
                  32'({g7(i + 1), (i == 63), (i + 1 >= 56), 7'(i + 1)}));
        end
        $display("fill done: wptr=%0b full=%0b af=%0b lvl=%0d", wptr, full, almost_full, wlevel);
        check("fill_wptr_gray64", 32'(wptr), 32'b1100000);

        // Writes attempted while full are dropped and latch overflow.
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            #1;
            check($sformatf("ovf_we[%0d]", i), 32'(mem_we), 32'd0);
            cyc();
            check($sformatf("ovf_reg[%0d]", i), 32'({wptr, full, overflow}), 32'({7'b1100000, 1'b1, 1'b1}));
        end
        wr_en = 1'b0;
        cyc();
        check("ovf_sticky", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        wr_en   = 1'b1;
        clr_ovf = 1'b1;
        cyc();
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
        check("ovf_set_wins", 32'(overflow), 32'd1);

        // Reader catches up to 32: room opens next cycle.
        rq2_rptr = 7'b0110000;
        cyc();
        check("drain32", 32'({full, almost_full, wlevel}), 32'({1'b0, 1'b0, 7'd32}));

        // Advance wbin to 127 keeping the FIFO nearly empty, then wrap.
        for (int wb = 64; wb < 127; wb++) begin
            rq2_rptr = g7(wb);
            wr_en    = 1'b1;
            cyc();
        end
        wr_en = 1'b0;
        check("pre_wrap", 32'({wptr, waddr, wlevel}), 32'({7'b1000000, 6'd63, 7'd1}));
        rq2_rptr = g7(100);
        wr_en    = 1'b1;
        #1;
        check("wrap_comb", 32'({mem_we, waddr}), 32'({1'b1, 6'd63}));
        cyc();
        check("wrap_reg", 32'({wptr, full, wlevel}), 32'({7'd0, 1'b0, 7'd28}));
        $display("wrap: wptr=%0h lvl=%0d full=%0b", wptr, wlevel, full);
        for (int j = 0; j < 36; j++) begin
            wr_en = 1'b1;
            cyc();
            check($sformatf("wrapfill[%0d]", j), 32'({full, almost_full, wlevel}),
                  32'({(j == 35), (j + 29 >= 56), 7'(j + 29)}));
        end
        check("wrapfill_wptr", 32'(wptr), 32'(g7(36)));
        #1;
        check("wrapfull_we", 32'(mem_we), 32'd0);

        // Asynchronous reset in the middle of a burst.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            wr_en = 1'b1;
            cyc();
        end
        check("burst_lvl40", 32'(wlevel), 32'd40);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'(snap()), 32'd0);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_reset_comb", 32'({mem_we, waddr}), 32'({1'b1, 6'd0}));
        cyc();
        check("post_reset_reg", 32'({wptr, wlevel}), 32'({7'd1, 7'd1}));
        wr_en = 1'b0;
        $display("reset mid-burst: wptr=%0h lvl=%0d", wptr, wlevel);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-side controller for the dual-clock FIFO, living entirely in the write clock domain.
- Owns the binary/Gray write pointer and drives the memory write enable and address.
- Generates full, almost_full, a write-side occupancy level and a sticky overflow flag.
- Consumes the Gray read pointer after it has passed through the 3-stage pointer synchronizer, so flag deassertion is pessimistic by design.

Parameters:
ADDR_WIDTH, 6, memory address width; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
AF_THRESH, 56, almost_full asserts when level >= AF_THRESH; legal range 1..2**ADDR_WIDTH.

Ports:
clk  input  1  write-domain clock.
rst_n  input  1  asynchronous, active-low reset.
wr_en  input  1  write request from producer.
rq2_rptr  input  ADDR_WIDTH+1  Gray read pointer, already synchronized into clk.
clr_ovf  input  1  clears sticky overflow.
mem_we  output  1  memory write strobe (combinational).
waddr  output  ADDR_WIDTH  memory write address (combinational from binary pointer).
wptr  output  ADDR_WIDTH+1  registered Gray write pointer, fed to the read-side synchronizer.
full  output  1  registered full flag.
almost_full  output  1  registered almost-full flag.
wlevel  output  ADDR_WIDTH+1  registered occupancy seen by the write side, 0..2**ADDR_WIDTH.
overflow  output  1  sticky flag: a write was attempted while full.

Behaviour:
Reset: wbin=0, wptr=0, full=0, almost_full=0, wlevel=0, overflow=0. Combinational outputs: mem_we=0, waddr=0.

Write acceptance:
- push = wr_en & ~full.
- mem_we = push; waddr = wbin[ADDR_WIDTH-1:0].
- wbin_next = wbin + push, modulo 2**(ADDR_WIDTH+1); wraps from all-ones to 0 with no special case.

Gray pointer:
- wptr <= bin2gray(wbin_next) every cycle.
- Exactly one bit of wptr changes per accepted write.
- wptr never changes without push.

Full flag:
- full <= (bin2gray(wbin_next) == {~rq2_rptr[MSB:MSB-1], rq2_rptr[MSB-2:0]}).
- Asserts in the cycle after the write that fills the last slot, with no bubble: back-to-back writes stop at exactly 2**ADDR_WIDTH entries.

Level:
- wlevel <= wbin_next - gray2bin(rq2_rptr), using (ADDR_WIDTH+1)-bit modular subtraction.
- The result is never above 2**ADDR_WIDTH.

Almost full:
- almost_full <= (level_next >= AF_THRESH), where level_next is the same value registered into wlevel.

Overflow:
- Set when wr_en & full.
- Cleared by clr_ovf.
- If set and clear occur in the same cycle, set wins.
- Held until cleared or reset.

Pessimism:
- Reads become visible only after the synchronizer latency of 3 clk cycles plus this block's 1-cycle register.
- full and almost_full may therefore stay high for up to 4 cycles after space exists; this is correct behaviour.
- The flags never deassert early.

Boundary cases:
- Simultaneous full and wr_en: the write is dropped, the pointer is unchanged, overflow is set.
- rq2_rptr changes in the same cycle as a push: both effects are reflected in the next-cycle flags.
- Reset mid-operation returns everything to the reset values immediately (asynchronous). The read side must be reset concurrently.

Decomposition:
Package fifo_pkg contains:
- FIFO_ADDR_WIDTH default constant;
- ptr_t typedef (logic [ADDR_WIDTH:0]);
- functions bin2gray and gray2bin, parameterized by width.

One sub-module, gray2bin_conv: a combinational XOR-prefix converter used on rq2_rptr. It is reusable by the read-side controller.

Test Plan:
- Reset, no writes, rq2_rptr=0: all outputs 0 and held for 10 cycles, including with wr_en=0.
- 64 back-to-back writes, rq2_rptr=0:
  - waddr runs 0..63;
  - after the 64th push, full=1;
  - wptr=7'b1100000 (gray(64));
  - wlevel=64;
  - almost_full rose the cycle after the 56th push.
- Full with wr_en=1 for 3 cycles: mem_we=0, wptr unchanged, overflow=1; overflow persists after wr_en drops; clr_ovf pulse clears it; clr_ovf together with another full write leaves overflow=1.
- Full state, then drive rq2_rptr=gray(32)=7'b0110000: next cycle full=0, wlevel=32, almost_full=0.
- Wrap-around:
  - preload by writing with rq2_rptr tracking, so wbin reaches 127;
  - one more push gives wbin=0, wptr=0;
  - full is computed correctly across the wrap with rq2_rptr=gray(100).
- Assert rst_n low mid-burst at level 40: all flags and pointers are 0 asynchronously; after release, the first write goes to waddr=0.
